mem_access_unit: RTL

Load/store stage directly downstream of the ALU. It consumes ALUResult as the effective address, along with store data and funct3 from the EX stage. It drives a word-addressed data-memory port over a req/ack handshake and returns sign- or zero-extended load data, or a fault code, to write-back. While it is busy it stalls the pipeline through req_ready.

---
 rtl/mem_access_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store stage: takes an EX-stage op, drives a word-addressed req/ack memory port, returns extended load data or a fault.
// Latency: accept -> ISSUE next cycle -> RESP one cycle after ack/timeout; req_ready is low (pipeline stall) whenever not IDLE.
module mem_access_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [1:0]            resp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                state, state_nxt;
  logic                  wr_q;
  logic [2:0]            f3_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            err_q;
  logic [CNT_WIDTH-1:0]  cnt;

  logic [1:0]            req_err;
  logic                  legal;
  logic [1:0]            lane;
  logic [DATA_WIDTH-1:0] rd_shift;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [3:0]            be_sel;
  logic [DATA_WIDTH-1:0] wd_rep;

  // Illegal funct3 is checked first so it masks any misalignment.
  always_comb begin
    req_err = 2'b00;
    if (req_write) legal = !req_funct3[2] && (req_funct3[1:0] != 2'b11);
    else           legal = (req_funct3[1:0] != 2'b11) && !(req_funct3[2] && req_funct3[1]);
    if (!legal) begin
      req_err = 2'b10;
    end else begin
      case (req_funct3[1:0])
        2'b01:   if (req_addr[0])          req_err = 2'b01;
        2'b10:   if (req_addr[1:0] != 2'b00) req_err = 2'b01;
        default: req_err = 2'b00;
      endcase
    end
  end

  // Lane steering from the captured op; loads reuse the same byte enables.
  always_comb begin
    lane     = addr_q[1:0];
    rd_shift = mem_rdata >> {lane, 3'b000};
    case (f3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, rd_shift[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
    case (f3_q[1:0])
      2'b00: begin
        be_sel = 4'b0001 << lane;
        wd_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_sel = 4'b0011 << lane;
        wd_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        be_sel = 4'b1111;
        wd_rep = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = (req_err == 2'b00) ? ISSUE : RESP;
      ISSUE:   if (mem_ack || cnt == CNT_LIMIT) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 2'b00;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= req_err;
            rdata_q <= '0;
            cnt     <= '0;
          end
        end
        ISSUE: begin
          // An ack on the final allowed cycle still completes normally.
          if (mem_ack) begin
            err_q   <= 2'b00;
            rdata_q <= wr_q ? '0 : load_ext;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LIMIT) err_q <= 2'b11;
          end
        end
        RESP:    cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = 4'b0000;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 2'b00;
    case (state)
      IDLE:  req_ready = 1'b1;
      ISSUE: begin
        mem_req   = 1'b1;
        mem_we    = wr_q;
        mem_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
        mem_be    = be_sel;
        mem_wdata = wd_rep;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule
